// File: rtl/ast_packet_arbiter_pkg.sv
// Shared types and constants for the Avalon-ST width-converter front end.
// Provides beat field types, arbiter defaults and the arbiter state enum.
package ast_packet_arbiter_pkg;

    localparam int DATA_IN_W  = 64;
    localparam int EMPTY_IN_W = 3;
    localparam int CHANNEL_W  = 10;

    typedef logic [EMPTY_IN_W-1:0] empty_in_t;
    typedef logic [CHANNEL_W-1:0]  channel_t;

    localparam int DEF_N_PORTS = 4;
    localparam int DEF_PORT_W  = $clog2(DEF_N_PORTS);

    typedef logic [DEF_PORT_W-1:0] port_idx_t;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

endpackage

// File: rtl/ast_packet_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping.
// Ports: req (request vector), last_grant -> gnt_idx, gnt_any.
module ast_packet_arbiter_rr_arbiter #(
    parameter int N_PORTS = 4,
    localparam int PORT_W = $clog2(N_PORTS)
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [PORT_W-1:0]  last_grant,
    output logic [PORT_W-1:0]  gnt_idx,
    output logic               gnt_any
);

    always_comb begin
        int idx;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = 0;
        // Offset 1..N so last_grant itself has lowest priority.
        for (int off = 1; off <= N_PORTS; off++) begin
            idx = (int'(last_grant) + off) % N_PORTS;
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PORT_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ast_packet_arbiter.sv
// Packet-atomic round-robin arbiter in front of the converter's sink.
// Ports: N_PORTS Avalon-ST sinks in, one Avalon-ST source out, grant_o/busy_o.
module ast_packet_arbiter #(
    parameter int N_PORTS   = ast_packet_arbiter_pkg::DEF_N_PORTS,
    parameter int DATA_W    = ast_packet_arbiter_pkg::DATA_IN_W,
    parameter int EMPTY_W   = ast_packet_arbiter_pkg::EMPTY_IN_W,
    parameter int CHANNEL_W = ast_packet_arbiter_pkg::CHANNEL_W,
    localparam int PORT_W   = $clog2(N_PORTS)
) (
    input  logic                              clk_i,
    input  logic                              arst_n_i,
    input  logic [N_PORTS-1:0][DATA_W-1:0]    ast_data_i,
    input  logic [N_PORTS-1:0][EMPTY_W-1:0]   ast_empty_i,
    input  logic [N_PORTS-1:0][CHANNEL_W-1:0] ast_channel_i,
    input  logic [N_PORTS-1:0]                ast_startofpacket_i,
    input  logic [N_PORTS-1:0]                ast_endofpacket_i,
    input  logic [N_PORTS-1:0]                ast_valid_i,
    output logic [N_PORTS-1:0]                ast_ready_o,
    output logic [DATA_W-1:0]                 ast_data_o,
    output logic [EMPTY_W-1:0]                ast_empty_o,
    output logic [CHANNEL_W-1:0]              ast_channel_o,
    output logic                              ast_startofpacket_o,
    output logic                              ast_endofpacket_o,
    output logic                              ast_valid_o,
    input  logic                              ast_ready_i,
    output logic [PORT_W-1:0]                 grant_o,
    output logic                              busy_o
);

    import ast_packet_arbiter_pkg::*;

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [PORT_W-1:0] grant_q;
    logic [PORT_W-1:0] grant_d;
    logic [PORT_W-1:0] last_q;
    logic [N_PORTS-1:0] req;
    logic [PORT_W-1:0] win_idx;
    logic              win_any;

    // Only a packet start may claim the output.
    assign req = ast_valid_i & ast_startofpacket_i;

    ast_packet_arbiter_rr_arbiter #(
        .N_PORTS(N_PORTS)
    ) u_rr (
        .req       (req),
        .last_grant(last_q),
        .gnt_idx   (win_idx),
        .gnt_any   (win_any)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= PORT_W'(N_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            if (state_q == ARB_IDLE && win_any) begin
                last_q <= win_idx;
            end
        end
    end

    always_comb begin
        state_d             = state_q;
        grant_d             = grant_q;
        ast_ready_o         = '0;
        ast_data_o          = '0;
        ast_empty_o         = '0;
        ast_channel_o       = '0;
        ast_startofpacket_o = 1'b0;
        ast_endofpacket_o   = 1'b0;
        ast_valid_o         = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (win_any) begin
                    state_d = ARB_LOCKED;
                    grant_d = win_idx;
                end
            end
            ARB_LOCKED: begin
                ast_data_o          = ast_data_i[grant_q];
                ast_empty_o         = ast_empty_i[grant_q];
                ast_channel_o       = ast_channel_i[grant_q];
                ast_startofpacket_o = ast_startofpacket_i[grant_q];
                ast_endofpacket_o   = ast_endofpacket_i[grant_q];
                ast_valid_o         = ast_valid_i[grant_q];
                ast_ready_o[grant_q] = ast_ready_i;
                // Release only when the eop beat is actually taken.
                if (ast_valid_o && ast_ready_i && ast_endofpacket_o) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    assign busy_o  = (state_q == ARB_LOCKED);
    assign grant_o = grant_q;

endmodule

// File: tb/tb_ast_packet_arbiter.sv
// Scoreboard bench for ast_packet_arbiter.
// Per-port source queues drive beats; accepted output beats pop the scoreboard.
module tb_ast_packet_arbiter;

    import ast_packet_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int DW = 64;
    localparam int EW = 3;
    localparam int CW = 10;
    localparam int PW = 2;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0][DW-1:0] data_i;
    logic [N-1:0][EW-1:0] empty_i;
    logic [N-1:0][CW-1:0] chan_i;
    logic [N-1:0]         sop_i;
    logic [N-1:0]         eop_i;
    logic [N-1:0]         valid_i;
    logic [N-1:0]         ready_o;
    logic [DW-1:0]        data_o;
    logic [EW-1:0]        empty_o;
    logic [CW-1:0]        chan_o;
    logic                 sop_o;
    logic                 eop_o;
    logic                 valid_o;
    logic                 ready_i;
    logic [PW-1:0]        grant_o;
    logic                 busy_o;

    ast_packet_arbiter dut (
        .clk_i              (clk),
        .arst_n_i           (arst_n),
        .ast_data_i         (data_i),
        .ast_empty_i        (empty_i),
        .ast_channel_i      (chan_i),
        .ast_startofpacket_i(sop_i),
        .ast_endofpacket_i  (eop_i),
        .ast_valid_i        (valid_i),
        .ast_ready_o        (ready_o),
        .ast_data_o         (data_o),
        .ast_empty_o        (empty_o),
        .ast_channel_o      (chan_o),
        .ast_startofpacket_o(sop_o),
        .ast_endofpacket_o  (eop_o),
        .ast_valid_o        (valid_o),
        .ast_ready_i        (ready_i),
        .grant_o            (grant_o),
        .busy_o             (busy_o)
    );

    typedef struct packed {
        logic [1:0]  port;
        logic [63:0] data;
        empty_in_t   empty;
        channel_t    chan;
        logic        sop;
        logic        eop;
    } beat_t;

    beat_t srcq[N][$];
    beat_t expq[$];
    bit    rdy_q[$];
    int    total = 0;
    int    bad = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    int    last_acc = -1;
    bit    gap_chk = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic pkt(input int p, input int n, input logic [63:0] base,
                       input logic [9:0] ch, input logic [2:0] emp_last,
                       input bit to_exp);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.port  = 2'(p);
            b.data  = base * 64'(i + 1);
            b.empty = (i == n - 1) ? emp_last : 3'd0;
            b.chan  = ch;
            b.sop   = (i == 0);
            b.eop   = (i == n - 1);
            srcq[p].push_back(b);
            if (to_exp) expq.push_back(b);
        end
    endtask

    // Source driver and output monitor in lockstep.
    initial begin : drv
        logic [N-1:0] acc;
        logic         prev_hold;
        logic         prev_eop;
        logic [63:0]  prev_data;
        beat_t        e;
        beat_t        f;
        acc = '0;
        prev_hold = 1'b0;
        prev_eop = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            acc = valid_i & ready_o;
            if (prev_eop) chk("bubble", 64'(busy_o), 64'd0);
            if (prev_hold) chk("hold", data_o, prev_data);
            if (busy_o) chk("rdy_mirror", 64'(ready_o[grant_o]), 64'(ready_i));
            if (valid_o && ready_i) begin
                acc_cnt++;
                if (gap_chk && last_acc >= 0)
                    chk("gap", 64'(cyc - last_acc), 64'd2);
                last_acc = cyc;
                if (expq.size() == 0) begin
                    chk("sb_empty", 64'(expq.size()), 64'd1);
                end else begin
                    e = expq.pop_front();
                    chk("grant", 64'(grant_o), 64'(e.port));
                    chk("data", data_o, e.data);
                    chk("empty", 64'(empty_o), 64'(e.empty));
                    chk("chan", 64'(chan_o), 64'(e.chan));
                    chk("sop", 64'(sop_o), 64'(e.sop));
                    chk("eop", 64'(eop_o), 64'(e.eop));
                end
            end
            prev_eop  = valid_o & ready_i & eop_o;
            prev_hold = valid_o & ~ready_i;
            prev_data = data_o;
            @(posedge clk);
            cyc++;
            #1;
            for (int p = 0; p < N; p++)
                if (acc[p] && srcq[p].size() > 0) void'(srcq[p].pop_front());
            for (int p = 0; p < N; p++) begin
                if (srcq[p].size() > 0) begin
                    f = srcq[p][0];
                    data_i[p]  = f.data;
                    empty_i[p] = f.empty;
                    chan_i[p]  = f.chan;
                    sop_i[p]   = f.sop;
                    eop_i[p]   = f.eop;
                    valid_i[p] = 1'b1;
                end else begin
                    data_i[p]  = '0;
                    empty_i[p] = '0;
                    chan_i[p]  = '0;
                    sop_i[p]   = 1'b0;
                    eop_i[p]   = 1'b0;
                    valid_i[p] = 1'b0;
                end
            end
            ready_i = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
        end
    end

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (expq.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(expq.size()), 64'd0);
        repeat (3) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst_n = 1'b0;
        for (int p = 0; p < N; p++) srcq[p].delete();
        expq.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin : tests
        int base;
        int n;
        data_i  = '0;
        empty_i = '0;
        chan_i  = '0;
        sop_i   = '0;
        eop_i   = '0;
        valid_i = '0;
        ready_i = 1'b1;

        @(negedge clk);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_ready", 64'(ready_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        arst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single source, latency of one cycle from sop to grant.
        pkt(2, 3, 64'h11, 10'd5, 3'd0, 1'b1);
        @(negedge clk);
        chk("lat_idle", 64'(busy_o), 64'd0);
        @(negedge clk);
        chk("lat_busy", 64'(busy_o), 64'd1);
        chk("lat_grant", 64'(grant_o), 64'd2);
        chk("lat_ready", 64'(ready_o), 64'b0100);
        wait_done(50);

        // Contention from a fresh reset: 0,1,3.
        do_reset();
        pkt(0, 2, 64'h100, 10'd1, 3'd1, 1'b1);
        pkt(1, 2, 64'h200, 10'd2, 3'd2, 1'b1);
        pkt(3, 2, 64'h300, 10'd3, 3'd3, 1'b1);
        wait_done(100);

        // Wrap-around: last grant 3, so 0 beats 3.
        pkt(0, 2, 64'h400, 10'd4, 3'd4, 1'b1);
        pkt(3, 2, 64'h500, 10'd6, 3'd5, 1'b1);
        wait_done(100);

        // Backpressure 1,0,0,1 once locked (first slot is the idle cycle).
        pkt(1, 3, 64'h600, 10'd9, 3'd7, 1'b1);
        rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b1);
        rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b0);
        rdy_q.push_back(1'b1);
        wait_done(100);

        // Continuous single-beat packets: strict rotation, 2 cycles apart.
        do_reset();
        gap_chk = 1'b1;
        last_acc = -1;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < N; p++)
                pkt(p, 1, 64'h1000 + 64'(16 * r + p), 10'(p), 3'(p), 1'b1);
        wait_done(100);
        gap_chk = 1'b0;

        // Reset on beat 2 of 4, then port 0 regains priority.
        pkt(2, 1, 64'hA1, 10'd7, 3'd0, 1'b1);
        srcq[2][0].eop = 1'b0;
        expq[0].eop = 1'b0;
        pkt(2, 3, 64'hA2, 10'd7, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) srcq[2][i + 1].sop = 1'b0;
        base = acc_cnt;
        n = 0;
        while (acc_cnt == base && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("rst_b1", 64'(acc_cnt - base), 64'd1);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 64'(valid_o), 64'd1);
        arst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(valid_o), 64'd0);
        chk("mid_rst_ready", 64'(ready_o), 64'd0);
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        srcq[2].delete();
        expq.delete();
        repeat (2) @(negedge clk);
        arst_n = 1'b1;
        pkt(0, 2, 64'hB0, 10'd8, 3'd2, 1'b1);
        pkt(2, 2, 64'hC0, 10'd9, 3'd3, 1'b1);
        wait_done(100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
